// File: rtl/seg7_pkg.sv
// Shared types and segment-pattern constants for the seven-segment word decoder.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } state_t;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg1 = 7'h79;
  localparam logic [6:0] Seg2 = 7'h24;
  localparam logic [6:0] Seg3 = 7'h30;
  localparam logic [6:0] Seg4 = 7'h19;
  localparam logic [6:0] Seg5 = 7'h12;
  localparam logic [6:0] Seg6 = 7'h02;
  localparam logic [6:0] Seg7 = 7'h78;
  localparam logic [6:0] Seg8 = 7'h00;
  localparam logic [6:0] Seg9 = 7'h10;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegB = 7'h03;
  localparam logic [6:0] SegC = 7'h46;
  localparam logic [6:0] SegD = 7'h21;
  localparam logic [6:0] SegE = 7'h06;
  localparam logic [6:0] SegF = 7'h0E;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder with legality flag.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    unique case (seg)
      Seg0:    nibble = 4'h0;
      Seg1:    nibble = 4'h1;
      Seg2:    nibble = 4'h2;
      Seg3:    nibble = 4'h3;
      Seg4:    nibble = 4'h4;
      Seg5:    nibble = 4'h5;
      Seg6:    nibble = 4'h6;
      Seg7:    nibble = 4'h7;
      Seg8:    nibble = 4'h8;
      Seg9:    nibble = 4'h9;
      SegA:    nibble = 4'hA;
      SegB:    nibble = 4'hB;
      SegC:    nibble = 4'hC;
      SegD:    nibble = 4'hD;
      SegE:    nibble = 4'hE;
      SegF:    nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_word_decoder.sv
// Reassembles a 16-bit word from four strobed seven-segment digits (0 first, 3 last).
// Optional input debounce: define SEG7_DEC_STABLE_EN to require STABLE_CNT identical strobes.
module seg7_word_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  digit_idx_t  digit_sel,
  input  logic        seg_valid,
  input  logic        word_ack,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        seg_err,
  output logic        seq_err
);

  logic [3:0]  nibble;
  logic        legal;
  logic        accept;
  logic [15:0] ins;

  state_t      state_q;
  digit_idx_t  k_q;
  logic [15:0] acc_q;
  logic [15:0] word_q;
  logic        word_valid_q;
  logic        seg_err_q;
  logic        seq_err_q;

  seg7_to_hex u_seg7_to_hex (
    .seg    (seg_in),
    .nibble (nibble),
    .legal  (legal)
  );

`ifdef SEG7_DEC_STABLE_EN
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      last_seg_q;
  digit_idx_t      last_sel_q;

  always_comb begin
    if (cnt_q != '0 && seg_in == last_seg_q && digit_sel == last_sel_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = CntW'(1);
    end
  end

  assign accept = seg_valid && (cnt_d == CntW'(STABLE_CNT));

  // Counter returns to zero on acceptance so a further identical run must restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      last_seg_q <= '0;
      last_sel_q <= '0;
    end else if (seg_valid) begin
      cnt_q      <= accept ? '0 : cnt_d;
      last_seg_q <= seg_in;
      last_sel_q <= digit_sel;
    end
  end
`else
  logic unused_stable;
  assign unused_stable = ^STABLE_CNT;
  assign accept        = seg_valid;
`endif

  assign ins = {12'h000, nibble} << {k_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      seg_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      seg_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      // In HOLD without an ack everything is ignored; with an ack the strobe is handled as IDLE.
      if (state_q != StHold || word_ack) begin
        if (state_q == StHold) begin
          word_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        if (accept) begin
          if (!legal) begin
            seg_err_q <= 1'b1;
            state_q   <= StIdle;
            k_q       <= '0;
            acc_q     <= '0;
          end else if (state_q != StCollect) begin
            if (digit_sel == '0) begin
              acc_q   <= {12'h000, nibble};
              k_q     <= 2'd1;
              state_q <= StCollect;
            end else begin
              seq_err_q <= 1'b1;
            end
          end else if (digit_sel == k_q) begin
            if (k_q == 2'd3) begin
              word_q       <= acc_q | ins;
              word_valid_q <= 1'b1;
              state_q      <= StHold;
              k_q          <= '0;
              acc_q        <= '0;
            end else begin
              acc_q <= acc_q | ins;
              k_q   <= k_q + 1'b1;
            end
          end else if (digit_sel == '0) begin
            acc_q     <= {12'h000, nibble};
            k_q       <= 2'd1;
            seq_err_q <= 1'b1;
          end else begin
            seq_err_q <= 1'b1;
            state_q   <= StIdle;
            k_q       <= '0;
            acc_q     <= '0;
          end
        end
      end
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign seg_err    = seg_err_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Directed self-checking bench for seg7_word_decoder.
module tb_seg7_word_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [1:0]  digit_sel = '0;
  logic        seg_valid = 1'b0;
  logic        word_ack = 1'b0;
  logic [15:0] word;
  logic        word_valid;
  logic        seg_err;
  logic        seq_err;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_word_decoder #(.STABLE_CNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .digit_sel  (digit_sel),
    .seg_valid  (seg_valid),
    .word_ack   (word_ack),
    .word       (word),
    .word_valid (word_valid),
    .seg_err    (seg_err),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic strobe(input logic [6:0] s, input logic [1:0] d);
    @(negedge clk);
    seg_in    = s;
    digit_sel = d;
    seg_valid = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    @(negedge clk);
    word_ack = 1'b1;
    @(posedge clk);
    #1;
    word_ack = 1'b0;
  endtask

  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] exp_words [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_word", word, 16'h0000);
    check("rst_valid", 16'(word_valid), 16'h0);
    check("rst_segerr", 16'(seg_err), 16'h0);
    check("rst_seqerr", 16'(seq_err), 16'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef SEG7_DEC_STABLE_EN
    // Two matching strobes then a different one: nothing accepted.
    strobe(7'h40, 2'd0);
    strobe(7'h40, 2'd0);
    strobe(7'h79, 2'd1);
    check("stb_noacc_seq", 16'(seq_err), 16'h0);
    repeat (3) strobe(7'h40, 2'd0);
    check("stb_d0_seq", 16'(seq_err), 16'h0);
    strobe(7'h77, 2'd1);
    check("stb_ill1", 16'(seg_err), 16'h0);
    strobe(7'h77, 2'd1);
    check("stb_ill2", 16'(seg_err), 16'h0);
    strobe(7'h40, 2'd1);
    check("stb_ill_then40", 16'(seg_err), 16'h0);
    repeat (3) strobe(7'h79, 2'd1);
    repeat (3) strobe(7'h24, 2'd2);
    check("stb_d2_valid", 16'(word_valid), 16'h0);
    repeat (3) strobe(7'h30, 2'd3);
    check("stb_word", word, 16'h3210);
    check("stb_valid", 16'(word_valid), 16'h1);
    ack();
    check("stb_ack", 16'(word_valid), 16'h0);
    strobe(7'h77, 2'd0);
    strobe(7'h77, 2'd0);
    check("stb_ill_pre", 16'(seg_err), 16'h0);
    strobe(7'h77, 2'd0);
    check("stb_ill_rep", 16'(seg_err), 16'h1);
    idle_cycle();
    check("stb_ill_pulse", 16'(seg_err), 16'h0);
`else
    // Every decode table entry, four words.
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++) strobe(tbl[w*4+i], 2'(i));
      check($sformatf("tbl_word%0d", w), word, exp_words[w]);
      check($sformatf("tbl_valid%0d", w), 16'(word_valid), 16'h1);
      ack();
    end

    // Basic assembly, hold, ignored strobe in HOLD, ack.
    strobe(7'h40, 2'd0);
    strobe(7'h79, 2'd1);
    strobe(7'h24, 2'd2);
    check("asm_d2_valid", 16'(word_valid), 16'h0);
    strobe(7'h30, 2'd3);
    check("asm_valid", 16'(word_valid), 16'h1);
    check("asm_word", word, 16'h3210);
    strobe(7'h00, 2'd2);
    check("hold_strobe_word", word, 16'h3210);
    check("hold_strobe_seq", 16'(seq_err), 16'h0);
    repeat (4) idle_cycle();
    check("hold_word", word, 16'h3210);
    check("hold_valid", 16'(word_valid), 16'h1);
    ack();
    check("ack_valid", 16'(word_valid), 16'h0);

    // Illegal pattern mid-assembly.
    strobe(7'h0E, 2'd0);
    strobe(7'h77, 2'd1);
    check("ill_segerr", 16'(seg_err), 16'h1);
    check("ill_seqerr", 16'(seq_err), 16'h0);
    idle_cycle();
    check("ill_pulse", 16'(seg_err), 16'h0);
    strobe(7'h77, 2'd2);
    check("prec_segerr", 16'(seg_err), 16'h1);
    check("prec_seqerr", 16'(seq_err), 16'h0);
    strobe(7'h06, 2'd0);
    strobe(7'h21, 2'd1);
    strobe(7'h46, 2'd2);
    strobe(7'h03, 2'd3);
    check("bcde_word", word, 16'hBCDE);
    ack();

    // Ordering errors.
    strobe(7'h40, 2'd0);
    strobe(7'h79, 2'd2);
    check("skip_seqerr", 16'(seq_err), 16'h1);
    idle_cycle();
    check("skip_pulse", 16'(seq_err), 16'h0);
    strobe(7'h79, 2'd1);
    check("idle_d1_seqerr", 16'(seq_err), 16'h1);
    strobe(7'h40, 2'd0);
    check("idle_d0_seqerr", 16'(seq_err), 16'h0);
    strobe(7'h79, 2'd1);
    strobe(7'h40, 2'd0);
    check("restart_seqerr", 16'(seq_err), 16'h1);
    strobe(7'h79, 2'd1);
    check("restart_k1", 16'(seq_err), 16'h0);
    strobe(7'h24, 2'd2);
    strobe(7'h30, 2'd3);
    check("restart_word", word, 16'h3210);
    check("restart_valid", 16'(word_valid), 16'h1);

    // Ack and digit-0 strobe in the same HOLD cycle.
    @(negedge clk);
    seg_in    = 7'h00;
    digit_sel = 2'd0;
    seg_valid = 1'b1;
    word_ack  = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    word_ack  = 1'b0;
    check("ackd0_valid", 16'(word_valid), 16'h0);
    check("ackd0_seqerr", 16'(seq_err), 16'h0);
    strobe(7'h79, 2'd1);
    strobe(7'h79, 2'd2);
    strobe(7'h79, 2'd3);
    check("ackd0_word", word, 16'h1118);
    check("ackd0_wvalid", 16'(word_valid), 16'h1);
    ack();

    // Ack outside HOLD is a no-op.
    strobe(7'h40, 2'd0);
    ack();
    strobe(7'h79, 2'd1);
    check("ack_collect_seq", 16'(seq_err), 16'h0);
    strobe(7'h24, 2'd2);
    strobe(7'h30, 2'd3);
    check("ack_collect_word", word, 16'h3210);
    check("ack_collect_valid", 16'(word_valid), 16'h1);
    ack();

    // Asynchronous reset mid-assembly.
    strobe(7'h40, 2'd0);
    strobe(7'h79, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_word", word, 16'h0000);
    check("arst_valid", 16'(word_valid), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    strobe(7'h24, 2'd1);
    check("arst_idle_seqerr", 16'(seq_err), 16'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg7_word_decoder.md
SEG7_WORD_DECODER -- requirements
Module: seg7_word_decoder

Interface
REQ-001 Parameter: STABLE_CNT, default 3, consecutive identical strobes needed to accept a digit (used only with SEG7_DEC_STABLE_EN).
REQ-002 Clock  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 SegIn  input  7  active-low segment pattern, bit 0 = segment a … bit 6 = segment g.
REQ-005 DigitSel  input  2  digit position of SegIn; 0 = nibble [3:0] … 3 = nibble [15:12].
REQ-006 SegValid  input  1  SegIn/DigitSel are valid this cycle (strobe).
REQ-007 WordAck  input  1  consumer accepts the held word.
REQ-008 Word  output  16  reassembled word, registered.
REQ-009 WordValid  output  1  Word holds a complete word; level, held until acked.
REQ-010 SegErr  output  1  one-cycle pulse: strobed pattern not in the decode table.
REQ-011 SeqErr  output  1  one-cycle pulse: digit received out of order.

Function
REQ-012 Decode table SHALL be the exact inverse of the team hex-to-7-segment encoder: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex values of SegIn); every other pattern is illegal.
REQ-013 FSM states: IDLE (expect digit 0), COLLECT (expect digit k, k = 1..3), HOLD (WordValid = 1).
REQ-014 IDLE: accepted digit 0 with legal pattern -> store nibble, COLLECT with k = 1; strobe with DigitSel != 0 -> stay IDLE, pulse SeqErr.
REQ-015 COLLECT: accepted digit k legal -> store nibble, k+1; after k = 3 -> HOLD.
REQ-016 COLLECT: DigitSel = 0 -> restart assembly with this nibble, k = 1, pulse SeqErr; any other DigitSel != k -> IDLE, pulse SeqErr, partial nibbles discarded.
REQ-017 Illegal pattern in IDLE or COLLECT -> pulse SegErr, go IDLE, partial nibbles discarded; SegErr takes precedence over SeqErr (only SegErr pulses).
REQ-018 Latency: strobe accepting digit 3 at edge t -> Word and WordValid updated at edge t+1; Word never changes while WordValid = 1.
REQ-019 HOLD: WordAck = 1 -> WordValid clears next edge, state IDLE; strobes without WordAck ignored, no error pulses.
REQ-020 HOLD with WordAck and legal digit-0 strobe in the same cycle -> WordValid clears, strobe accepted, state COLLECT k = 1.
REQ-021 WordAck outside HOLD SHALL have no effect.
REQ-022 Error pulses last exactly one cycle per offending strobe; SegValid = 0 cycles never change state.

Reset
REQ-023 Reset asserted -> immediately: Word = 0000, WordValid = 0, SegErr = 0, SeqErr = 0, state IDLE, k = 0, stability counter 0, partial nibbles 0.
REQ-024 Reset mid-assembly or in HOLD SHALL discard all data; first edge after deassertion behaves as IDLE.

Configuration
REQ-025 Macro SEG7_DEC_STABLE_EN defined: a digit is accepted only on the STABLE_CNT-th consecutive SegValid strobe with identical SegIn and DigitSel; a differing strobe restarts the count at 1 without error; an illegal pattern is reported only once it reaches STABLE_CNT; ordering checks apply only to accepted digits.
REQ-026 Macro undefined: every SegValid strobe is accepted immediately (equivalent to STABLE_CNT = 1); STABLE_CNT ignored; no counter logic synthesized.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16 segment-pattern constants, the FSM state enum and the digit-index type.
REQ-028 One sub-module seg7_to_hex: combinational 7-bit pattern -> 4-bit nibble plus legal flag; instantiated once.

Verification
REQ-029 Strobes d0=40, d1=79, d2=24, d3=30 (macro off) -> WordValid = 1 one edge after d3, Word = 3210; hold 5 cycles -> Word unchanged; WordAck -> WordValid = 0 next edge.
REQ-030 d0=0E, d1=77 -> SegErr pulses one cycle, state IDLE; then full sequence 06,21,46,03 -> Word = BCDE.
REQ-031 d0=40, d2=79 -> SeqErr pulse, IDLE; d1 strobe in IDLE -> SeqErr pulse; d0=40 during COLLECT k = 2 -> SeqErr pulse, restart with k = 1.
REQ-032 In HOLD (Word = 3210) assert WordAck with d0=00 the same cycle -> WordValid = 0, then 79,79,79 for d1..d3 -> Word = 1118.
REQ-033 Macro on, STABLE_CNT = 3: d0=40 twice then 79 -> no accept; 40 three times consecutively -> accepted; illegal 77 twice then 40 -> no SegErr.
REQ-034 Reset asserted after d0, d1 accepted -> outputs zero immediately; after release, d1 strobe -> SeqErr (confirms IDLE).
